// File: rtl/uart_resp_serializer_if.sv
// Handshake bundle between a response producer, uart_resp_serializer and uart_tx.
// slave: serializer side (data_i/valid_i/done_i in; ready_o/data_o/start_o out).
// master: producer/transmitter side, the mirror image.
interface uart_resp_serializer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [7:0]            data_o;
    logic                  start_o;
    logic                  done_i;

    modport slave (
        input  data_i,
        input  valid_i,
        input  done_i,
        output ready_o,
        output data_o,
        output start_o
    );

    modport master (
        output data_i,
        output valid_i,
        output done_i,
        input  ready_o,
        input  data_o,
        input  start_o
    );
endinterface

// File: rtl/uart_resp_serializer.sv
// Serializes a DATA_WIDTH-bit response word into an ASCII frame for uart_tx:
// PREAMBLE, DATA_WIDTH/4 hex digits (MSB nibble first), CR, LF.
// Ports: clk, rst (sync, active-high), bus (slave modport: data_i, valid_i,
// ready_o, data_o, start_o, done_i).
// Option: define UART_RESP_SERIALIZER_LOWERCASE_EN for lowercase hex letters.
module uart_resp_serializer #(
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] PREAMBLE   = 8'h4D
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_resp_serializer_if.slave bus
);
    localparam int NIB = DATA_WIDTH / 4;
    localparam int N   = NIB + 3;
    localparam int IW  = $clog2(N);

`ifdef UART_RESP_SERIALIZER_LOWERCASE_EN
    localparam logic [7:0] ALPHA_BASE = 8'h57;
`else
    localparam logic [7:0] ALPHA_BASE = 8'h37;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] word;
    logic                  wait_first;
    logic [3:0]            nib;
    logic [7:0]            cur_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return ALPHA_BASE + {4'h0, n};
    endfunction

    // Byte currently addressed by idx; hex digits walk from the MSB nibble.
    always_comb begin
        nib      = 4'h0;
        cur_byte = 8'h0A;
        unique case (1'b1)
            (idx == '0):
                cur_byte = PREAMBLE;
            (idx != '0 && int'(idx) <= NIB): begin
                nib      = 4'(word >> (4 * (NIB - int'(idx))));
                cur_byte = hex_char(nib);
            end
            (int'(idx) == N - 2):
                cur_byte = 8'h0D;
            default:
                cur_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            word        <= '0;
            wait_first  <= 1'b0;
            bus.ready_o <= 1'b1;
            bus.start_o <= 1'b0;
            bus.data_o  <= 8'h00;
        end else begin
            bus.start_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.valid_i && bus.ready_o) begin
                        word        <= bus.data_i;
                        idx         <= '0;
                        bus.ready_o <= 1'b0;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.done_i) begin
                        bus.data_o  <= cur_byte;
                        bus.start_o <= 1'b1;
                        wait_first  <= 1'b1;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // uart_tx lowers done one cycle after start, so the
                    // first WAIT cycle still sees the stale idle flag.
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (bus.done_i) begin
                        if (idx == IW'(N - 1)) begin
                            bus.ready_o <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    bus.ready_o <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_resp_serializer.sv
// Testbench for uart_resp_serializer: uart_tx model, byte-stream reference
// model built from the frame rules, directed and random words.
module tb_uart_resp_serializer;
    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;
`ifdef UART_RESP_SERIALIZER_LOWERCASE_EN
    localparam int ALPHA = 97;
`else
    localparam int ALPHA = 65;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_resp_serializer_if #(.DATA_WIDTH(16)) bus ();
    uart_resp_serializer_if #(.DATA_WIDTH(8))  bus8 ();

    uart_resp_serializer #(.DATA_WIDTH(16), .PREAMBLE(8'h4D)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    uart_resp_serializer #(.DATA_WIDTH(8), .PREAMBLE(8'h4D)) dut8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8)
    );

    // uart_tx models: busy for a full 10-bit frame after each accepted start
    logic stall = 1'b0;
    logic busy  = 1'b0;
    logic busy8 = 1'b0;
    int   cnt   = 0;
    int   cnt8  = 0;

    assign bus.done_i  = !busy && !stall;
    assign bus8.done_i = !busy8;

    always @(posedge clk) begin
        if (bus.start_o && bus.done_i) begin
            busy <= 1'b1;
            cnt  <= FRAME - 1;
        end else if (busy) begin
            if (cnt == 0) busy <= 1'b0;
            else cnt <= cnt - 1;
        end
        if (bus8.start_o && bus8.done_i) begin
            busy8 <= 1'b1;
            cnt8  <= FRAME - 1;
        end else if (busy8) begin
            if (cnt8 == 0) busy8 <= 1'b0;
            else cnt8 <= cnt8 - 1;
        end
    end

    // byte monitor plus protocol watch (start only when idle, one cycle wide)
    logic [7:0] got[$];
    logic [7:0] got8[$];
    logic [7:0] exp_q[$];
    int         viol   = 0;
    logic       prev_s = 1'b0;
    logic       prev_s8 = 1'b0;

    always @(negedge clk) begin
        if (bus.start_o) begin
            got.push_back(bus.data_o);
            if (!bus.done_i || prev_s) viol++;
        end
        if (bus8.start_o) begin
            got8.push_back(bus8.data_o);
            if (!bus8.done_i || prev_s8) viol++;
        end
        prev_s  = bus.start_o;
        prev_s8 = bus8.start_o;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // reference frame: 'M', hex digits MSB first, CR, LF
    function automatic void add_frame(input logic [15:0] w, input int nd);
        int d;
        exp_q.push_back(8'h4D);
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'((w >> (4 * i)) & 16'hF);
            if (d < 10) exp_q.push_back(8'(48 + d));
            else exp_q.push_back(8'(ALPHA + d - 10));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic cmp(input string tag, input bit use8);
        int n;
        n = use8 ? got8.size() : got.size();
        check({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i),
                  int'(use8 ? got8[i] : got[i]), int'(exp_q[i]));
        got.delete();
        got8.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [15:0] w);
        int k = 0;
        while (!bus.ready_o && k < 3000) begin
            tick();
            k++;
        end
        check("ready_before_send", int'(bus.ready_o), 1);
        bus.data_i  = w;
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        check("ready_drop", int'(bus.ready_o), 0);
    endtask

    task automatic wait_done(input int nbytes);
        int k = 0;
        while ((got.size() < nbytes || !bus.ready_o) && k < 5000) begin
            tick();
            k++;
        end
        check("frame_timeout", int'(k < 5000), 1);
    endtask

    task automatic run_word(input string tag, input logic [15:0] w);
        send(w);
        add_frame(w, 4);
        wait_done(7);
        cmp(tag, 1'b0);
    endtask

    initial begin
        int k;
        logic [15:0] fixed[4];
        fixed[0] = 16'h1234;
        fixed[1] = 16'hBEEF;
        fixed[2] = 16'h0000;
        fixed[3] = 16'hFFFF;

        bus.data_i   = '0;
        bus.valid_i  = 1'b0;
        bus8.data_i  = '0;
        bus8.valid_i = 1'b0;

        // reset state, with valid_i asserted: rst must win
        bus.valid_i = 1'b1;
        tick(2);
        check("rst_ready", int'(bus.ready_o), 1);
        check("rst_start", int'(bus.start_o), 0);
        check("rst_data", int'(bus.data_o), 0);
        bus.valid_i = 1'b0;
        rst = 1'b0;
        tick(3);
        check("rst_no_capture", got.size(), 0);

        // fixed patterns, including hex letters and boundary values
        for (int i = 0; i < 4; i++)
            run_word($sformatf("fixed%0d", i), fixed[i]);

        // busy rejection, then back-to-back acceptance
        bus.data_i  = 16'h00FF;
        bus.valid_i = 1'b1;
        tick();
        check("busy_accept", int'(bus.ready_o), 0);
        bus.data_i = 16'hAAAA;
        k = 0;
        while (!bus.ready_o && k < 3000) begin
            tick();
            k++;
        end
        check("busy_ready_back", int'(bus.ready_o), 1);
        tick();
        bus.valid_i = 1'b0;
        check("busy_reaccept", int'(bus.ready_o), 0);
        add_frame(16'h00FF, 4);
        add_frame(16'hAAAA, 4);
        wait_done(14);
        cmp("busy", 1'b0);

        // transmitter stall before the first byte
        stall = 1'b1;
        send(16'h1234);
        tick(50);
        check("stall_quiet", got.size(), 0);
        stall = 1'b0;
        tick();
        check("stall_release", got.size(), 1);
        add_frame(16'h1234, 4);
        wait_done(7);
        cmp("stall", 1'b0);

        // reset after the third byte
        send(16'h1234);
        k = 0;
        while (got.size() < 3 && k < 3000) begin
            tick();
            k++;
        end
        check("midrst_reach3", got.size(), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", int'(bus.ready_o), 1);
        tick(300);
        check("midrst_dropped", got.size(), 3);
        got.delete();
        run_word("after_rst", 16'h0001);

        // random words
        for (int i = 0; i < 4; i++)
            run_word($sformatf("rand%0d", i), 16'($urandom));

        // 8-bit instance: N = 5
        bus8.data_i  = 8'h5A;
        bus8.valid_i = 1'b1;
        tick();
        bus8.valid_i = 1'b0;
        check("w8_ready_drop", int'(bus8.ready_o), 0);
        k = 0;
        while ((got8.size() < 5 || !bus8.ready_o) && k < 5000) begin
            tick();
            k++;
        end
        check("w8_timeout", int'(k < 5000), 1);
        add_frame(16'h005A, 2);
        cmp("w8", 1'b1);

        check("start_protocol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
